// File: rtl/seq_scan_pkg.sv
// Shared state encodings for the scan controller and its pattern-detector core.
package seq_scan_pkg;

    typedef enum logic [2:0] {
        START = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S11   = 3'd3,
        S110  = 3'd4,
        S100  = 3'd5,
        S1001 = 3'd6,
        S1100 = 3'd7
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Register-side handshake and status bundle of the scan controller.
interface seq_scan_ctrl_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          start;
    logic [W-1:0]  din;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt1100;
    logic [CW-1:0] cnt1001;
    logic          bit_out;
    logic [2:0]    det_state;

    modport master (
        output start, din,
        input  busy, done, cnt1100, cnt1001, bit_out, det_state
    );

    modport slave (
        input  start, din,
        output busy, done, cnt1100, cnt1001, bit_out, det_state
    );
endinterface

// File: rtl/seq_det_core.sv
// Moore detector for the serial patterns 1100 (y1) and 1001 (y2).
module seq_det_core
    import seq_scan_pkg::*;
(
    input  logic       ck,
    input  logic       rs,
    input  logic       clr,
    input  logic       en,
    input  logic       x,
    output logic       y1,
    output logic       y2,
    output logic [2:0] state
);
    det_state_t st, st_nxt;

    always_comb begin
        st_nxt = st;
        case (st)
            START: st_nxt = x ? S1    : START;
            S1:    st_nxt = x ? S11   : S10;
            S10:   st_nxt = x ? S1    : S100;
            S11:   st_nxt = x ? S11   : S110;
            S110:  st_nxt = x ? S1    : S1100;
            S100:  st_nxt = x ? S1001 : S10;
            S1001: st_nxt = x ? S11   : S10;
            S1100: st_nxt = x ? S1001 : START;
            default: st_nxt = START;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rs || clr)
            st <= START;
        else if (en)
            st <= st_nxt;
    end

    assign y1    = (st == S1100);
    assign y2    = (st == S1001);
    assign state = st;
endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: loads a word, shifts it MSB-first through the detector and
// counts pattern hits in saturating counters before pulsing done.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic ck,
    input  logic rs,
    seq_scan_ctrl_if.slave bus
);
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    ctrl_state_t   state, state_nxt;
    logic [W-1:0]  shreg;
    logic [BW-1:0] bitcnt;
    logic [CW-1:0] c1100, c1001;
    logic          accept, busy, done, det_en, det_clr, bit_out;
    logic          y1, y2;
    logic [2:0]    det_state;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        det_en    = 1'b0;
        det_clr   = 1'b0;
        bit_out   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    det_clr   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                det_en  = 1'b1;
                bit_out = shreg[W-1];
                if (bitcnt == LAST_BIT)
                    state_nxt = DRAIN;
            end
            // Extra cycle so the detector output for the last bit gets counted.
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            c1100  <= '0;
            c1001  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg  <= bus.din;
                bitcnt <= '0;
                c1100  <= '0;
                c1001  <= '0;
            end else begin
                if (state == SHIFT) begin
                    shreg  <= {shreg[W-2:0], 1'b0};
                    bitcnt <= bitcnt + 1'b1;
                end
                if (busy && y1 && (c1100 != '1))
                    c1100 <= c1100 + 1'b1;
                if (busy && y2 && (c1001 != '1))
                    c1001 <= c1001 + 1'b1;
            end
        end
    end

    seq_det_core u_det (
        .ck    (ck),
        .rs    (rs),
        .clr   (det_clr),
        .en    (det_en),
        .x     (bit_out),
        .y1    (y1),
        .y2    (y2),
        .state (det_state)
    );

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.cnt1100   = c1100;
    assign bus.cnt1001   = c1001;
    assign bus.bit_out   = bit_out;
    assign bus.det_state = det_state;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed and random scans on a W=8/CW=4 and a
// W=16/CW=2 instance, checked against a table-driven detector model.
module tb_seq_scan_ctrl;
    localparam int WA = 8;
    localparam int CA = 4;
    localparam int WB = 16;
    localparam int CB = 2;

    logic ck = 1'b0;
    logic rs = 1'b1;
    always #5 ck = ~ck;

    seq_scan_ctrl_if #(.W(WA), .CW(CA)) ia ();
    seq_scan_ctrl_if #(.W(WB), .CW(CB)) ib ();

    seq_scan_ctrl #(.W(WA), .CW(CA)) u_a (.ck(ck), .rs(rs), .bus(ia));
    seq_scan_ctrl #(.W(WB), .CW(CB)) u_b (.ck(ck), .rs(rs), .bus(ib));

    int n_vec = 0;
    int n_err = 0;

    // Detector transition table, [state][x], states numbered START=0..S1100=7.
    int nxt_tbl [8][2] = '{'{0, 1}, '{2, 3}, '{5, 1}, '{4, 3},
                           '{7, 1}, '{2, 6}, '{2, 3}, '{0, 6}};
    int exp_st [17];
    int exp_c1, exp_c2;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // exp_st[k] is the detector state after k bits; hits are counted on every
    // state seen from the first SHIFT cycle through DRAIN.
    function automatic void model(input logic [15:0] w, input int n, input int cw);
        int sat;
        sat = (1 << cw) - 1;
        exp_st[0] = 0;
        exp_c1 = 0;
        exp_c2 = 0;
        for (int k = 0; k < n; k++)
            exp_st[k+1] = nxt_tbl[exp_st[k]][int'(w[n-1-k])];
        for (int k = 0; k <= n; k++) begin
            if (exp_st[k] == 7 && exp_c1 < sat) exp_c1++;
            if (exp_st[k] == 6 && exp_c2 < sat) exp_c2++;
        end
    endfunction

    task automatic scan_a(input logic [WA-1:0] w, input bit noise);
        logic [15:0] w16;
        w16 = 16'(w);
        model(w16, WA, CA);
        ia.start = 1'b1;
        ia.din   = w;
        tick();
        ia.start = 1'b0;
        for (int k = 1; k <= WA; k++) begin
            check("a_shift_busy", int'(ia.busy), 1);
            check("a_shift_done", int'(ia.done), 0);
            check("a_bit_out", int'(ia.bit_out), int'(w[WA-k]));
            check("a_det_state", int'(ia.det_state), exp_st[k-1]);
            if (noise) begin
                ia.start = 1'($urandom);
                ia.din   = WA'($urandom);
            end
            tick();
        end
        ia.start = 1'b0;
        check("a_drain_busy", int'(ia.busy), 1);
        check("a_drain_bit", int'(ia.bit_out), 0);
        check("a_drain_state", int'(ia.det_state), exp_st[WA]);
        if (noise) ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        check("a_done", int'(ia.done), 1);
        check("a_done_busy", int'(ia.busy), 0);
        check("a_cnt1100", int'(ia.cnt1100), exp_c1);
        check("a_cnt1001", int'(ia.cnt1001), exp_c2);
        if (noise) ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        check("a_idle_done", int'(ia.done), 0);
        check("a_idle_busy", int'(ia.busy), 0);
        check("a_hold_1100", int'(ia.cnt1100), exp_c1);
        check("a_hold_1001", int'(ia.cnt1001), exp_c2);
    endtask

    task automatic scan_b(input logic [WB-1:0] w);
        model(w, WB, CB);
        ib.start = 1'b1;
        ib.din   = w;
        tick();
        ib.start = 1'b0;
        for (int k = 1; k <= WB + 1; k++) begin
            check("b_busy", int'(ib.busy), 1);
            tick();
        end
        check("b_done", int'(ib.done), 1);
        check("b_cnt1100", int'(ib.cnt1100), exp_c1);
        check("b_cnt1001", int'(ib.cnt1001), exp_c2);
        tick();
        check("b_idle_done", int'(ib.done), 0);
    endtask

    initial begin
        bit saw_done;
        ia.start = 1'b0;
        ia.din   = '0;
        ib.start = 1'b0;
        ib.din   = '0;
        rs = 1'b1;
        tick();
        tick();
        rs = 1'b0;
        check("rst_busy", int'(ia.busy), 0);
        check("rst_done", int'(ia.done), 0);
        check("rst_cnt1100", int'(ia.cnt1100), 0);
        check("rst_cnt1001", int'(ia.cnt1001), 0);
        check("rst_bit_out", int'(ia.bit_out), 0);
        check("rst_det_state", int'(ia.det_state), 0);
        tick();

        scan_a(8'b1100_1100, 1'b0);
        scan_a(8'b1100_1001, 1'b0);
        scan_a(8'hFF, 1'b0);
        scan_a(8'h00, 1'b0);
        scan_a(8'b1100_1100, 1'b1);
        for (int i = 0; i < 10; i++)
            scan_a(WA'($urandom), 1'($urandom));

        scan_b(16'hCCCC);
        for (int i = 0; i < 4; i++)
            scan_b(WB'($urandom));

        // Reset during the 4th SHIFT cycle aborts the scan with no done pulse.
        ia.start = 1'b1;
        ia.din   = 8'b1100_1100;
        tick();
        ia.start = 1'b0;
        repeat (3) tick();
        rs = 1'b1;
        tick();
        rs = 1'b0;
        check("abort_busy", int'(ia.busy), 0);
        check("abort_cnt1100", int'(ia.cnt1100), 0);
        check("abort_cnt1001", int'(ia.cnt1001), 0);
        check("abort_det_state", int'(ia.det_state), 0);
        check("abort_bit_out", int'(ia.bit_out), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ia.done) saw_done = 1'b1;
            tick();
        end
        check("abort_no_done", int'(saw_done), 0);
        scan_a(8'b1100_1100, 1'b0);

        // start held high: acceptance every WA+3 cycles, counters cleared each time.
        scan_a(8'h99, 1'b0);
        model(16'h00CC, WA, CA);
        ia.start = 1'b1;
        ia.din   = 8'hCC;
        tick();
        for (int cyc = 1; cyc <= 2 * (WA + 3); cyc++) begin
            check("b2b_done", int'(ia.done),
                  ((cyc == WA + 2) || (cyc == 2 * WA + 5)) ? 1 : 0);
            if (cyc == 1 || cyc == WA + 4) begin
                check("b2b_clr1100", int'(ia.cnt1100), 0);
                check("b2b_clr1001", int'(ia.cnt1001), 0);
            end
            if (ia.done) begin
                check("b2b_cnt1100", int'(ia.cnt1100), exp_c1);
                check("b2b_cnt1001", int'(ia.cnt1001), exp_c2);
            end
            tick();
        end
        ia.start = 1'b0;
        repeat (WA + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Scan controller that sequences a serial pattern-detector core. It accepts a parallel W-bit word on a start handshake, clears the detector, and shifts the word MSB-first into the detector one bit per clock. It counts occurrences of the patterns 1100 and 1001 in saturating counters, then pulses done. It sits between a parallel register interface and the detector datapath, and is the only block that drives the detector's bit input and enable.

## Interface
- W, 8, scan word width (≥4)
- CW, 4, width of each match counter
- ck  in  1  clock, all logic on rising edge
- rs  in  1  reset, synchronous, active-high
- start  in  1  request a scan; sampled only in IDLE
- din  in  W  word to scan; captured on the accepting edge
- busy  out  1  high in SHIFT and DRAIN
- done  out  1  one-cycle pulse in DONE
- cnt1100  out  CW  count of detector y1 (1100) assertions in the last scan
- cnt1001  out  CW  count of detector y2 (1001) assertions in the last scan
- bit_out  out  1  serial bit currently presented to the detector
- det_state  out  3  detector present state, for debug

## Operation
- Controller FSM: IDLE, SHIFT, DRAIN, DONE.
- IDLE with start=1 at an edge:
  - go to SHIFT
  - shreg<=din; bitcnt<=0
  - cnt1100<=0, cnt1001<=0
  - detector synchronously cleared to START
- IDLE with start=0: hold.
- SHIFT:
  - bit_out=shreg[W-1], det_en=1
  - each edge: shreg shifts left (zero fill) and bitcnt increments
  - after the W-th bit (bitcnt==W-1 at the edge), go to DRAIN
- DRAIN:
  - det_en=0
  - exists so the Moore output for the last bit is sampled
  - next edge goes to DONE
- DONE: done=1, busy=0; next edge goes to IDLE. A start seen in this cycle is ignored.
- Counting:
  - In SHIFT or DRAIN, if y1=1 at an edge, cnt1100 increments; likewise y2 increments cnt1001.
  - Both counters saturate at 2^CW-1.
  - Both hold their values from DONE until the next accepted start.
- start while busy: ignored, with no effect on the scan.
- Detector (Moore, 3-bit state):
  - States: START=0, S1=1, S10=2, S11=3, S110=4, S100=5, S1001=6, S1100=7.
  - Next state as x=0/x=1:
    - START: START/S1
    - S1: S10/S11
    - S10: S100/S1
    - S11: S110/S11
    - S110: S1100/S1
    - S100: S10/S1001
    - S1001: S10/S11
    - S1100: START/S1001
  - y1=(state==S1100), y2=(state==S1001).
  - When en=0 the state holds; clr has priority over en.
- bit_out=0 outside SHIFT.

## Timing
- Reset at an edge with rs=1, overriding everything including an in-progress scan:
  - controller goes to IDLE, detector to START
  - busy=0, done=0, cnt1100=0, cnt1001=0, bit_out=0, det_state=0
  - no done pulse is generated for an aborted scan
- Start accepted at edge E0:
  - SHIFT occupies the W cycles after E0
  - DRAIN is 1 cycle, then DONE is 1 cycle
  - done is high during cycle W+2 after E0
  - the next start can be accepted at the edge ending DONE+1, i.e. 1 IDLE cycle minimum
- Counters are final and stable when done=1.
- Throughput: one word per W+3 cycles.

## Structure
- Package seq_scan_pkg holds:
  - the 3-bit detector state constants (START..S1100)
  - the 2-bit controller state constants (IDLE, SHIFT, DRAIN, DONE)
- Sub-module seq_det_core:
  - ports: ck, rs, clr, en, x, y1, y2, state
  - implements the detector table above
- seq_scan_ctrl contains the controller FSM, shift register, bit counter and saturating counters, and instantiates one seq_det_core.

## Test plan
- W=8, din=8'b1100_1100 with start -> busy for 9 cycles, done 10 cycles after acceptance; cnt1100=2, cnt1001=1. The det_state sequence is S1, S11, S110, S1100, S1001, S11, S110, S1100.
- W=8, din=8'b1100_1001 -> cnt1100=1, cnt1001=2; din=8'hFF -> 0,0; din=8'h00 -> 0,0.
- W=16, CW=2, din=16'hCCCC -> raw counts of 4 and 3 both saturate, giving cnt1100=3 and cnt1001=3.
- start pulsed during SHIFT and during DONE -> ignored. The counts equal the single-scan result and only one done pulse is produced.
- rs=1 in the 4th SHIFT cycle -> next cycle busy=0, counters=0, det_state=0, no done. A following start with 8'b1100_1100 gives 2,1.
- Back-to-back: start held high continuously -> a new scan is accepted every W+3 cycles, and the counters are cleared on each acceptance.
